// File: rtl/a2s_pkg.sv
// a2s_pkg: state encoding and width helpers shared by the ANN-to-SNN scheduler
package a2s_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, RESP} state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int idx_w(input int t);
        return $clog2(t) + 1;
    endfunction
endpackage

// File: rtl/a2s_rr_arbiter.sv
// a2s_rr_arbiter: combinational round-robin pick, searching upward from ptr and wrapping
module a2s_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             any
);
    // first set request at or after ptr wins
    always_comb begin
        grant = '0;
        id = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % N_REQ]) begin
                any = 1'b1;
                id = ID_W'((int'(ptr) + i) % N_REQ);
                grant[(int'(ptr) + i) % N_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ann_to_snn_scheduler.sv
// ann_to_snn_scheduler: time-shares one ann_to_snn_converter among N_REQ requesters.
// Define A2S_SCHED_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES and report expiry on rsp_err.
module ann_to_snn_scheduler
    import a2s_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int T              = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = id_w(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*T*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]         conv_data,
    output logic                          conv_valid,
    input  logic [T-1:0]                  conv_spike,
    input  logic                          conv_spike_valid,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [T-1:0]                  rsp_spikes,
    output logic                          rsp_err,
    output logic                          busy
);
    localparam int CW = idx_w(T);
    localparam int BW = T * DATA_WIDTH;
    if (N_REQ < 2 || T < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ann_to_snn_scheduler: N_REQ>=2, T>=2, TIMEOUT_CYCLES>=1 required");
    end
    state_t                       state;
    logic [ID_W-1:0]              rr_ptr, id_q, pick_id;
    logic [N_REQ-1:0]             pick_grant;
    logic                         pick_any;
    logic [T-1:0][DATA_WIDTH-1:0] burst_q;
    logic [CW-1:0]                idx;
    logic [T-1:0]                 spikes_q;
`ifdef A2S_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt;
    logic          err_q;
`endif
    a2s_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );
    // scheduler FSM: grant, stream the latched burst, wait for spikes, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            id_q <= '0;
            burst_q <= '0;
            idx <= '0;
            spikes_q <= '0;
`ifdef A2S_SCHED_TIMEOUT_EN
            wcnt <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|req_valid) state <= GRANT;
                GRANT: begin
                    if (pick_any) begin
                        id_q <= pick_id;
                        burst_q <= req_data[pick_id*BW +: BW];
                        idx <= '0;
                        state <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    idx <= idx + 1'b1;
`ifdef A2S_SCHED_TIMEOUT_EN
                    wcnt <= '0;
`endif
                    if (idx == CW'(T - 1)) state <= WAIT;
                end
                WAIT: begin
                    if (conv_spike_valid) begin
                        spikes_q <= conv_spike;
`ifdef A2S_SCHED_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                        state <= RESP;
                    end
`ifdef A2S_SCHED_TIMEOUT_EN
                    else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        spikes_q <= '0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                        state <= (|req_valid) ? GRANT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign req_ready  = (state == GRANT) ? pick_grant : '0;
    assign conv_valid = state == SEND;
    assign conv_data  = conv_valid ? burst_q[idx[CW-2:0]] : '0;
    assign rsp_valid  = state == RESP;
    assign rsp_id     = id_q;
    assign rsp_spikes = spikes_q;
    assign busy       = state != IDLE;
`ifdef A2S_SCHED_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_ann_to_snn_scheduler.sv
// tb_ann_to_snn_scheduler: directed bench with a stub converter and a transaction-level model
module tb_ann_to_snn_scheduler;
    localparam int N = 4, DW = 8, T = 4, TO = 64, IW = $clog2(N);
    logic              clk = 1'b0, rst = 1'b1;
    logic [N-1:0]      req_valid = '0, req_ready;
    logic [N*T*DW-1:0] req_data = '0;
    logic [DW-1:0]     conv_data;
    logic              conv_valid;
    logic [T-1:0]      conv_spike = '0;
    logic              conv_spike_valid = 1'b0;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [IW-1:0]     rsp_id;
    logic [T-1:0]      rsp_spikes;
    int tests = 0, fails = 0;

    ann_to_snn_scheduler #(.N_REQ(N), .DATA_WIDTH(DW), .T(T), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .conv_data(conv_data), .conv_valid(conv_valid), .conv_spike(conv_spike),
        .conv_spike_valid(conv_spike_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_spikes(rsp_spikes), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // stub converter: spike_valid 3 cycles after the last value, spike bit k = (value k >= 8)
    bit stub_off = 0, spur = 0;
    logic [DW-1:0] s_vals [T];
    int s_idx = 0, s_cnt = 0;
    initial forever begin
        @(negedge clk);
        conv_spike_valid = 1'b0;
        if (rst) begin
            s_idx = 0;
            s_cnt = 0;
        end else begin
            if (s_cnt > 0) begin
                s_cnt--;
                if (s_cnt == 0 && !stub_off) begin
                    conv_spike_valid = 1'b1;
                    for (int k = 0; k < T; k++) conv_spike[k] = s_vals[k] >= 8;
                end
            end
            if (conv_valid) begin
                if (spur && s_idx == 1) begin
                    conv_spike_valid = 1'b1;
                    conv_spike = 4'b1010;
                    spur = 0;
                end
                s_vals[s_idx] = conv_data;
                s_idx++;
                if (s_idx == T) begin
                    s_idx = 0;
                    s_cnt = 3;
                end
            end
        end
    end

    // transaction model: round-robin pick, T-beat stream after each grant, response contents
    int mptr = 0, mid = 0, pending = 0, resp_count = 0;
    bit inflight = 0, armed = 0, expect_timeout = 0;
    logic [DW-1:0] mvals [T];
    logic [T-1:0]  mspk = '0;
    int grants[$];

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [N-1:0] oh;
        if (armed) begin
            if (pending > 0) begin
                chk("conv_valid_send", conv_valid, 1);
                chk("conv_data", conv_data, mvals[T - pending]);
                pending--;
            end else begin
                chk("conv_valid_quiet", conv_valid, 0);
            end
            if (inflight) chk("busy_inflight", busy, 1);
            if (req_ready != '0) begin
                g = rr_pick(req_valid, mptr);
                chk("grant_while_inflight", inflight, 0);
                chk("grant_has_req", g >= 0, 1);
                if (g >= 0) begin
                    oh = '0;
                    oh[g] = 1'b1;
                    chk("grant_onehot", req_ready, oh);
                    mid = g;
                    grants.push_back(g);
                    for (int k = 0; k < T; k++) begin
                        mvals[k] = req_data[(g * T + k) * DW +: DW];
                        mspk[k] = mvals[k] >= 8;
                    end
                    pending = T;
                    inflight = 1;
                end
            end
            if (rsp_valid) begin
                chk("rsp_inflight", inflight, 1);
                chk("rsp_id", rsp_id, mid);
                chk("rsp_spikes", rsp_spikes, expect_timeout ? '0 : mspk);
`ifdef A2S_SCHED_TIMEOUT_EN
                chk("rsp_err", rsp_err, expect_timeout);
`else
                chk("rsp_err", rsp_err, 0);
`endif
                if (rsp_ready) begin
                    inflight = 0;
                    mptr = (mid + 1) % N;
                    resp_count++;
                end
            end
        end
        if (rst) begin
            armed = 1;
            mptr = 0;
            pending = 0;
            inflight = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_burst(input int i, input logic [DW-1:0] a, b, c, d);
        req_data[(i * T + 0) * DW +: DW] = a;
        req_data[(i * T + 1) * DW +: DW] = b;
        req_data[(i * T + 2) * DW +: DW] = c;
        req_data[(i * T + 3) * DW +: DW] = d;
    endtask

    task automatic wait_rsp(input int lim, output int n);
        n = 0;
        while (!rsp_valid && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || inflight) && n < lim) begin
            tick();
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no $finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_conv_valid", conv_valid, 0);
        chk("rst_conv_data", conv_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_spikes", rsp_spikes, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        set_burst(0, 1, 2, 3, 4);
        set_burst(1, 8, 9, 10, 11);
        set_burst(2, 8, 8, 8, 8);
        set_burst(3, 7, 8, 0, 255);
        rsp_ready = 1'b1;
        // single requester, latency and stream contents
        req_valid = 4'b0100;
        tick();
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_busy", busy, 1);
        tick();
        req_valid = '0;
        for (int k = 0; k < T; k++) begin
            chk("t1_conv_valid", conv_valid, 1);
            chk("t1_conv_data", conv_data, 8);
            tick();
        end
        chk("t1_stream_end", conv_valid, 0);
        wait_rsp(20, n);
        chk("t1_rsp_latency", n, 3);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_spikes", rsp_spikes, 4'b1111);
        chk("t1_rsp_err", rsp_err, 0);
        tick();
        chk("t1_rsp_done", rsp_valid, 0);
        // all requesters held: grant order from pointer 0
        do_reset();
        grants.delete();
        req_valid = '1;
        n = 0;
        while (grants.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("t2_grants_seen", grants.size(), 5);
        for (int i = 0; i < 5; i++) if (grants.size() > i) chk("t2_order", grants[i], i % N);
        wait_idle(100);
        // response back-pressure
        rsp_ready = 1'b0;
        req_valid = '1;
        wait_rsp(40, n);
        chk("t3_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_id", rsp_id, 1);
            chk("t3_hold_spikes", rsp_spikes, 4'b1111);
            chk("t3_no_grant", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_next_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_idle(100);
        // spurious spike_valid during SEND
        set_burst(3, 9, 1, 9, 1);
        spur = 1;
        req_valid = 4'b1000;
        tick();
        chk("t4_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_rsp(30, n);
        chk("t4_latency", n, 7);
        chk("t4_spur_sent", spur, 0);
        chk("t4_rsp_spikes", rsp_spikes, 4'b0101);
        wait_idle(100);
        // reset in the middle of SEND
        req_valid = 4'b0010;
        tick();
        tick();
        req_valid = '0;
        wait_idle(100);
        req_valid = 4'b0100;
        tick();
        chk("t5_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("t5_send1", conv_valid, 1);
        tick();
        chk("t5_send2", conv_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_conv_valid", conv_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        req_valid = '1;
        tick();
        chk("t5_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_idle(100);
        // converter never answers
        stub_off = 1;
`ifdef A2S_SCHED_TIMEOUT_EN
        expect_timeout = 1;
`endif
        req_valid = 4'b0010;
        tick();
        tick();
        req_valid = '0;
        n = 0;
        while (conv_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t6_send_len", n, T);
        wait_rsp(200, n);
`ifdef A2S_SCHED_TIMEOUT_EN
        chk("t6_timeout_at", n, TO);
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_rsp_spikes", rsp_spikes, 0);
        tick();
        expect_timeout = 0;
        wait_idle(10);
`else
        chk("t6_no_rsp", rsp_valid, 0);
        chk("t6_wait_len", n, 200);
        do_reset();
`endif
        stub_off = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
